// File: rtl/acc_program_sequencer_if.sv
// ROM fetch and datapath bus between the program sequencer and its two slaves.
// The master drives the ROM strobe/address and datapath controls; the slaves return data.
interface acc_program_sequencer_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W+2:0] rom_data;
   logic [DATA_W-1:0] acc_in;
   logic [2:0]        opcode;
   logic [DATA_W-1:0] Data_bus_in;
   logic              dp_en;
   logic              st_we;
   logic [DATA_W-1:0] st_data;

   modport master (
      output rom_en, rom_addr, opcode, Data_bus_in, dp_en, st_we, st_data,
      input  rom_data, acc_in
   );

   modport slave (
      input  rom_en, rom_addr, opcode, Data_bus_in, dp_en, st_we, st_data,
      output rom_data, acc_in
   );
endinterface

// File: rtl/acc_program_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Runs a program from a synchronous ROM, resolving JMP/JZ/HALT and a step watchdog locally.
module acc_program_sequencer #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_STEPS = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   acc_program_sequencer_if.master bus,
   output logic [ADDR_W-1:0]     pc,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] OpAdd   = 3'b000;
   localparam logic [2:0] OpLoad  = 3'b001;
   localparam logic [2:0] OpStore = 3'b010;
   localparam logic [2:0] OpJmp   = 3'b011;
   localparam logic [2:0] OpJz    = 3'b100;
   localparam logic [2:0] OpHalt  = 3'b111;

   typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [2:0]        ir_op_q, ir_op_d;
   logic [DATA_W-1:0] ir_operand_q, ir_operand_d;
   logic [15:0]       steps_q, steps_d;
   logic              err_q, err_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= '0;
         ir_op_q      <= OpStore;
         ir_operand_q <= '0;
         steps_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_op_q      <= ir_op_d;
         ir_operand_q <= ir_operand_d;
         steps_q      <= steps_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      ir_op_d         = ir_op_q;
      ir_operand_d    = ir_operand_q;
      steps_d         = steps_q;
      err_d           = err_q;
      bus.rom_en      = 1'b0;
      bus.rom_addr    = pc_q;
      // STORE with a zero operand leaves the datapath accumulator untouched
      bus.opcode      = OpStore;
      bus.Data_bus_in = '0;
      bus.dp_en       = 1'b0;
      bus.st_we       = 1'b0;
      bus.st_data     = '0;
      done            = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               pc_d    = start_addr;
               steps_d = '0;
               err_d   = 1'b0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            bus.rom_en = 1'b1;
            state_d    = StDecode;
         end
         StDecode: begin
            ir_op_d      = bus.rom_data[DATA_W+2:DATA_W];
            ir_operand_d = bus.rom_data[DATA_W-1:0];
            state_d      = StExec;
         end
         StExec: begin
            steps_d = steps_q + 16'd1;
            pc_d    = pc_q + ADDR_W'(1);
            case (ir_op_q)
               OpAdd, OpLoad: begin
                  bus.opcode      = ir_op_q;
                  bus.Data_bus_in = ir_operand_q;
                  bus.dp_en       = 1'b1;
               end
               OpStore: begin
                  bus.opcode      = ir_op_q;
                  bus.Data_bus_in = ir_operand_q;
                  bus.dp_en       = 1'b1;
                  bus.st_we       = 1'b1;
                  bus.st_data     = bus.acc_in;
               end
               OpJmp: pc_d = ir_operand_q[ADDR_W-1:0];
               OpJz: begin
                  if (bus.acc_in == '0) pc_d = ir_operand_q[ADDR_W-1:0];
               end
               default: ;
            endcase
            // HALT counts as a step but takes precedence over the watchdog
            if (ir_op_q == OpHalt) begin
               state_d = StHalt;
            end else if (steps_d == 16'(MAX_STEPS)) begin
               state_d = StHalt;
               err_d   = 1'b1;
            end else begin
               state_d = StFetch;
            end
         end
         StHalt: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign pc   = pc_q;
   assign busy = (state_q != StIdle);
   assign err  = err_q;

endmodule
